rs_issue_scheduler: RTL and testbench

- Per-FU reservation station and issue scheduler between Dispatch and one functional unit (ALU, LSU or branch instance).
- Accepts dispatched rs_issue_packet_t entries and tracks source-operand readiness via physical-tag wakeup from the CDB.
- Each cycle, selects the oldest ready entry (by ROB age relative to ROB head) and hands it to the FU through a registered valid/ready output stage.
- Supplies the RS-ready status Dispatch uses to stall.

---
 rtl/pipeline_types.sv | 41 ++++
 rtl/rs_issue_scheduler_age_select.sv | 31 +++
 rtl/rs_issue_scheduler.sv | 164 ++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared pipeline types for the reservation station and issue scheduler.
// Holds the dispatch/issue packet, the RS entry record and the tag constants.
// Widths here must match the TAG_W/PREG_W parameters of the RS instances.
package pipeline_types;

   localparam int PKT_TAG_W  = 4;
   localparam int PKT_PREG_W = 6;

   // Physical register 0 is hard-wired x0 and therefore always ready.
   localparam logic [PKT_PREG_W-1:0] PREG_ZERO = '0;

   typedef struct packed {
      logic [31:0]           pc;
      logic [31:0]           imm;
      logic [3:0]            alu_op;
      logic                  alu_src;
      logic                  mem_read;
      logic                  mem_write;
      logic [PKT_PREG_W-1:0] rs1_p;
      logic [PKT_PREG_W-1:0] rs2_p;
      logic [PKT_PREG_W-1:0] rd_p;
      logic [PKT_TAG_W-1:0]  rob_tag;
   } rs_issue_packet_t;

   typedef struct packed {
      logic             valid;
      logic             rs1_rdy;
      logic             rs2_rdy;
      rs_issue_packet_t pkt;
   } rs_entry_t;

   // A source is ready if the busy table says so, it is x0, or the CDB
   // is broadcasting its tag in the same cycle.
   function automatic logic src_ready(input logic                  busy_rdy,
                                      input logic                  cdb_vld,
                                      input logic [PKT_PREG_W-1:0] cdb_preg,
                                      input logic [PKT_PREG_W-1:0] src_p);
      return busy_rdy || (src_p == PREG_ZERO) || (cdb_vld && (cdb_preg == src_p));
   endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Oldest-ready picker: one-hot grant to the requesting slot with smallest age.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module age_select #(
   parameter int N     = 8,
   parameter int AGE_W = 4
) (
   input  logic [N-1:0]            req_i,
   input  logic [N-1:0][AGE_W-1:0] age_i,
   output logic [N-1:0]            gnt_o,
   output logic                    found_o
);

   logic [AGE_W-1:0] best_age;

   // Linear scan keeping the smallest age seen so far; ages are unique.
   always_comb begin
      gnt_o    = '0;
      found_o  = 1'b0;
      best_age = '0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && (!found_o || (age_i[i] < best_age))) begin
            found_o  = 1'b1;
            best_age = age_i[i];
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Per-FU reservation station: holds dispatched ops, wakes sources from the CDB,
// issues the oldest ready op through a registered valid/ready stage (1 cycle after ready).
// Backpressure: output stage holds while FU stalls; rs_ready_o drops when all entries are used.
module rs_issue_scheduler
   import pipeline_types::*;
#(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = PKT_TAG_W,
   parameter int PREG_W = PKT_PREG_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       disp_valid_i,
   input  rs_issue_packet_t           disp_pkt_i,
   input  logic                       disp_rs1_rdy_i,
   input  logic                       disp_rs2_rdy_i,
   output logic                       rs_ready_o,
   input  logic                       cdb_valid_i,
   input  logic [PREG_W-1:0]          cdb_preg_i,
   input  logic [TAG_W-1:0]           rob_head_i,
   input  logic                       flush_i,
   output logic                       issue_valid_o,
   output rs_issue_packet_t           issue_pkt_o,
   input  logic                       issue_ready_i,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;

   rs_entry_t [DEPTH-1:0]         entries_q;
   rs_entry_t [DEPTH-1:0]         entries_d;
   logic [OCC_W-1:0]              occ_q;
   logic [OCC_W-1:0]              occ_d;
   logic                          issue_valid_q;
   rs_issue_packet_t              issue_pkt_q;

   logic [DEPTH-1:0]              req;
   logic [DEPTH-1:0][TAG_W-1:0]   ages;
   logic [DEPTH-1:0]              gnt;
   logic                          found;
   rs_issue_packet_t              win_pkt;
   logic                          load;
   logic                          sel_fire;
   logic                          free_found;
   logic [IDX_W-1:0]              free_idx;
   logic                          alloc;

   assign load       = !issue_valid_q || issue_ready_i;
   assign sel_fire   = load && found;
   assign alloc      = disp_valid_i && free_found;

   assign rs_ready_o    = (occ_q != OCC_W'(DEPTH));
   assign occupancy_o   = occ_q;
   assign issue_valid_o = issue_valid_q;
   assign issue_pkt_o   = issue_pkt_q;

   // Candidates and their ROB age relative to head, from registered state only.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         req[i]  = entries_q[i].valid && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
         ages[i] = entries_q[i].pkt.rob_tag - rob_head_i;
      end
   end

   age_select #(
      .N     (DEPTH),
      .AGE_W (TAG_W)
   ) u_age_select (
      .req_i   (req),
      .age_i   (ages),
      .gnt_o   (gnt),
      .found_o (found)
   );

   // One-hot mux of the granted entry's packet.
   always_comb begin
      win_pkt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt[i]) begin
            win_pkt = entries_q[i].pkt;
         end
      end
   end

   // Lowest-index free slot; a slot freed by this cycle's issue is not yet visible.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!entries_q[i].valid) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Next entry state: CDB wakeup, release of the issued entry, then allocation.
   always_comb begin
      entries_d = entries_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries_q[i].valid && cdb_valid_i) begin
            if (entries_q[i].pkt.rs1_p == cdb_preg_i) begin
               entries_d[i].rs1_rdy = 1'b1;
            end
            if (entries_q[i].pkt.rs2_p == cdb_preg_i) begin
               entries_d[i].rs2_rdy = 1'b1;
            end
         end
         if (sel_fire && gnt[i]) begin
            entries_d[i].valid = 1'b0;
         end
         if (alloc && (free_idx == IDX_W'(i))) begin
            entries_d[i].valid   = 1'b1;
            entries_d[i].pkt     = disp_pkt_i;
            entries_d[i].rs1_rdy = src_ready(disp_rs1_rdy_i, cdb_valid_i, cdb_preg_i,
                                             disp_pkt_i.rs1_p);
            entries_d[i].rs2_rdy = src_ready(disp_rs2_rdy_i, cdb_valid_i, cdb_preg_i,
                                             disp_pkt_i.rs2_p);
         end
      end
   end

   // Occupancy tracks RS entries only; the output register is not counted.
   always_comb begin
      occ_d = occ_q + OCC_W'(alloc) - OCC_W'(sel_fire);
   end

   // State update: reset, then flush (kills everything incl. same-cycle dispatch), then normal.
   always_ff @(posedge clk) begin
      if (rst) begin
         entries_q     <= '0;
         occ_q         <= '0;
         issue_valid_q <= 1'b0;
         issue_pkt_q   <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].valid <= 1'b0;
         end
         occ_q         <= '0;
         issue_valid_q <= 1'b0;
      end else begin
         entries_q <= entries_d;
         occ_q     <= occ_d;
         if (load) begin
            issue_valid_q <= found;
            if (found) begin
               issue_pkt_q <= win_pkt;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Dispatch while full is dropped by the RS; flag it as an upstream protocol error.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         assert (!(disp_valid_i && !free_found))
            else $error("rs_issue_scheduler: dispatch while full, packet dropped");
      end
   end
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed-vector bench for rs_issue_scheduler with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises FU stall, full RS and flush.
module tb_rs_issue_scheduler;
   import pipeline_types::*;

   logic             clk;
   logic             rst;
   logic             disp_valid_i;
   rs_issue_packet_t disp_pkt_i;
   logic             disp_rs1_rdy_i;
   logic             disp_rs2_rdy_i;
   logic             rs_ready_o;
   logic             cdb_valid_i;
   logic [5:0]       cdb_preg_i;
   logic [3:0]       rob_head_i;
   logic             flush_i;
   logic             issue_valid_o;
   rs_issue_packet_t issue_pkt_o;
   logic             issue_ready_i;
   logic [3:0]       occupancy_o;

   int checks = 0;
   int errors = 0;

   rs_issue_scheduler #(.DEPTH(8), .TAG_W(4), .PREG_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .disp_valid_i   (disp_valid_i),
      .disp_pkt_i     (disp_pkt_i),
      .disp_rs1_rdy_i (disp_rs1_rdy_i),
      .disp_rs2_rdy_i (disp_rs2_rdy_i),
      .rs_ready_o     (rs_ready_o),
      .cdb_valid_i    (cdb_valid_i),
      .cdb_preg_i     (cdb_preg_i),
      .rob_head_i     (rob_head_i),
      .flush_i        (flush_i),
      .issue_valid_o  (issue_valid_o),
      .issue_pkt_o    (issue_pkt_o),
      .issue_ready_i  (issue_ready_i),
      .occupancy_o    (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic rs_issue_packet_t mk(input int tag, input int r1, input int r2);
      rs_issue_packet_t p;
      p         = '0;
      p.pc      = 32'h1000 + 32'(tag) * 4;
      p.imm     = 32'(tag) + 32'd100;
      p.alu_op  = 4'(tag);
      p.alu_src = tag[0];
      p.rs1_p   = 6'(r1);
      p.rs2_p   = 6'(r2);
      p.rd_p    = 6'(tag + 1);
      p.rob_tag = 4'(tag);
      return p;
   endfunction

   task automatic disp(input rs_issue_packet_t p, input logic r1, input logic r2);
      disp_valid_i   = 1'b1;
      disp_pkt_i     = p;
      disp_rs1_rdy_i = r1;
      disp_rs2_rdy_i = r2;
      step();
      disp_valid_i   = 1'b0;
   endtask

   rs_issue_packet_t p2;

   initial begin
      rst = 1'b1; disp_valid_i = 1'b0; disp_pkt_i = '0; disp_rs1_rdy_i = 1'b0;
      disp_rs2_rdy_i = 1'b0; cdb_valid_i = 1'b0; cdb_preg_i = '0; rob_head_i = '0;
      flush_i = 1'b0; issue_ready_i = 1'b1;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_issue_valid", 128'(issue_valid_o), 128'(0));
      check("rst_issue_pkt", 128'(issue_pkt_o), 128'(0));
      check("rst_occ", 128'(occupancy_o), 128'(0));
      check("rst_rs_ready", 128'(rs_ready_o), 128'(1));

      // Ready-at-dispatch op issues one edge after the dispatch edge
      disp(mk(3, 1, 2), 1'b1, 1'b1);
      check("t3_occ_after_disp", 128'(occupancy_o), 128'(1));
      check("t3_no_issue_yet", 128'(issue_valid_o), 128'(0));
      step();
      check("t3_issue_valid", 128'(issue_valid_o), 128'(1));
      check("t3_issue_pkt", 128'(issue_pkt_o), 128'(mk(3, 1, 2)));
      check("t3_occ_zero", 128'(occupancy_o), 128'(0));
      step();
      check("t3_drained", 128'(issue_valid_o), 128'(0));

      // rs1 waits on preg 12; unrelated broadcast must not wake it
      disp(mk(5, 12, 13), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cdb_valid_i = 1'b1; cdb_preg_i = 6'd20;
         check("t5_wait", 128'(issue_valid_o), 128'(0));
         step();
      end
      cdb_valid_i = 1'b1; cdb_preg_i = 6'd12;
      step();
      cdb_valid_i = 1'b0;
      check("t5_wakeup_edge", 128'(issue_valid_o), 128'(0));
      step();
      check("t5_issue_valid", 128'(issue_valid_o), 128'(1));
      check("t5_issue_tag", 128'(issue_pkt_o.rob_tag), 128'(5));
      step();

      // Dispatch-time CDB match on rs1 plus rs2 = x0 with busy bits low
      cdb_valid_i = 1'b1; cdb_preg_i = 6'd21;
      disp(mk(6, 21, 0), 1'b0, 1'b0);
      cdb_valid_i = 1'b0;
      step();
      check("t6_issue_valid", 128'(issue_valid_o), 128'(1));
      check("t6_issue_tag", 128'(issue_pkt_o.rob_tag), 128'(6));
      step();
      check("t6_drained", 128'(issue_valid_o), 128'(0));

      // Wrap-around age: head 14, order 14, 15, 1
      rob_head_i = 4'd14;
      disp(mk(1, 30, 0), 1'b0, 1'b1);
      disp(mk(15, 30, 0), 1'b0, 1'b1);
      disp(mk(14, 30, 0), 1'b0, 1'b1);
      check("age_occ", 128'(occupancy_o), 128'(3));
      cdb_valid_i = 1'b1; cdb_preg_i = 6'd30;
      step();
      cdb_valid_i = 1'b0;
      check("age_none_yet", 128'(issue_valid_o), 128'(0));
      step();
      check("age_first", 128'(issue_pkt_o.rob_tag), 128'(14));
      step();
      check("age_second", 128'(issue_pkt_o.rob_tag), 128'(15));
      step();
      check("age_third", 128'(issue_pkt_o.rob_tag), 128'(1));
      check("age_third_valid", 128'(issue_valid_o), 128'(1));
      step();
      check("age_drained", 128'(issue_valid_o), 128'(0));
      rob_head_i = 4'd0;

      // Fill all entries with not-ready ops
      for (int i = 0; i < 8; i++) begin
         disp(mk(i, 40 + i, 0), 1'b0, 1'b1);
      end
      check("full_occ", 128'(occupancy_o), 128'(8));
      check("full_rs_ready", 128'(rs_ready_o), 128'(0));
      check("full_no_issue", 128'(issue_valid_o), 128'(0));
      cdb_valid_i = 1'b1; cdb_preg_i = 6'd43;
      step();
      cdb_valid_i = 1'b0;
      check("full_still_full", 128'(rs_ready_o), 128'(0));
      step();
      check("full_issue_tag", 128'(issue_pkt_o.rob_tag), 128'(3));
      check("full_issue_valid", 128'(issue_valid_o), 128'(1));
      check("full_occ_7", 128'(occupancy_o), 128'(7));
      check("full_rs_ready_back", 128'(rs_ready_o), 128'(1));
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("full_flush_occ", 128'(occupancy_o), 128'(0));

      // FU stall holds the output, then three back-to-back issues
      issue_ready_i = 1'b0;
      p2 = mk(2, 1, 2);
      disp(p2, 1'b1, 1'b1);
      step();
      check("hold_valid", 128'(issue_valid_o), 128'(1));
      check("hold_tag", 128'(issue_pkt_o.rob_tag), 128'(2));
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            disp_valid_i = 1'b1; disp_pkt_i = mk(4 + i, 1, 2);
            disp_rs1_rdy_i = 1'b1; disp_rs2_rdy_i = 1'b1;
         end else begin
            disp_valid_i = 1'b0;
         end
         step();
         check("hold_pkt_stable", 128'(issue_pkt_o), 128'(p2));
         check("hold_valid_stable", 128'(issue_valid_o), 128'(1));
      end
      disp_valid_i = 1'b0;
      check("hold_occ", 128'(occupancy_o), 128'(3));
      issue_ready_i = 1'b1;
      step();
      check("b2b_1", 128'(issue_pkt_o.rob_tag), 128'(4));
      step();
      check("b2b_2", 128'(issue_pkt_o.rob_tag), 128'(5));
      step();
      check("b2b_3", 128'(issue_pkt_o.rob_tag), 128'(6));
      check("b2b_3_valid", 128'(issue_valid_o), 128'(1));
      step();
      check("b2b_drained", 128'(issue_valid_o), 128'(0));

      // Flush with 6 entries plus a held output, coincident with a dispatch
      issue_ready_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         disp(mk(i, 1, 2), 1'b1, 1'b1);
      end
      check("fl_occ6", 128'(occupancy_o), 128'(6));
      check("fl_out_valid", 128'(issue_valid_o), 128'(1));
      check("fl_out_tag", 128'(issue_pkt_o.rob_tag), 128'(0));
      flush_i = 1'b1;
      disp_valid_i = 1'b1; disp_pkt_i = mk(9, 1, 2);
      disp_rs1_rdy_i = 1'b1; disp_rs2_rdy_i = 1'b1;
      step();
      flush_i = 1'b0; disp_valid_i = 1'b0;
      check("fl_occ0", 128'(occupancy_o), 128'(0));
      check("fl_valid0", 128'(issue_valid_o), 128'(0));
      check("fl_rs_ready", 128'(rs_ready_o), 128'(1));
      issue_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("fl_no_ghost", 128'(issue_valid_o), 128'(0));
      end
      check("fl_occ_end", 128'(occupancy_o), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
